axi_stream_cache_scheduler: RTL and testbench

//  Packet-level round-robin scheduler that shares one wide stream cache (dual-FIFO 96-143 bit cache)

---
 rtl/axi_stream_cache_scheduler.sv | 166 ++++++++++++++++
 tb/tb_axi_stream_cache_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_cache_scheduler.sv
// Packet-level round-robin scheduler in front of a shared stream cache write port.
// Also sequences the cache FIFO reset (hold, then settle) at power-up and on flush.
module axi_stream_cache_scheduler #(
    parameter int NUM         = 4,
    parameter int DSIZE       = 128,
    parameter int RST_CYCLES  = 8,
    parameter int WAIT_CYCLES = 8
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [NUM*DSIZE-1:0]    s_tdata,
    input  logic [NUM-1:0]          s_tvalid,
    input  logic [NUM-1:0]          s_tlast,
    output logic [NUM-1:0]          s_tready,
    output logic [DSIZE-1:0]        m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic [$clog2(NUM)-1:0]  m_tdest,
    input  logic                    m_tready,
    input  logic                    flush_req,
    output logic                    flush_ack,
    output logic                    cache_rst,
    output logic                    busy
);

    localparam int DW   = $clog2(NUM);
    localparam int CMAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int CW   = $clog2(CMAX);

    localparam logic [DW-1:0] LAST_PORT = DW'(NUM - 1);
    localparam logic [DW:0]   NUM_W     = (DW + 1)'(NUM);
    localparam logic [CW-1:0] HOLD_END  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_END  = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RST_WAIT = 2'd1,
        IDLE     = 2'd2,
        PASS     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] grant_q, grant_d;
    logic [DW-1:0] last_grant_q, last_grant_d;

    logic [DSIZE-1:0] port_data [NUM];
    logic [DW-1:0]    cand_idx  [NUM];
    logic [NUM-1:0]   cand_valid;
    logic             arb_found;
    logic [DW-1:0]    arb_idx;
    logic             pass_en;

    // Candidate gi is the port gi+1 places after the last completed grant.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_port
            logic [DW:0] cand_sum;

            assign port_data[gi]  = s_tdata[gi*DSIZE +: DSIZE];
            assign cand_sum       = {1'b0, last_grant_q} + (DW + 1)'(gi + 1);
            assign cand_idx[gi]   = (cand_sum >= NUM_W) ? DW'(cand_sum - NUM_W)
                                                        : cand_sum[DW-1:0];
            assign cand_valid[gi] = s_tvalid[cand_idx[gi]];
            assign s_tready[gi]   = pass_en & (grant_q == DW'(gi)) & m_tready;
        end
    endgenerate

    // Ripple priority chain: the nearest valid candidate wins.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_arb
            logic          found;
            logic [DW-1:0] idx;
            if (gi == 0) begin : g_first
                assign found = cand_valid[0];
                assign idx   = cand_idx[0];
            end else begin : g_next
                assign found = g_arb[gi-1].found | cand_valid[gi];
                assign idx   = g_arb[gi-1].found ? g_arb[gi-1].idx : cand_idx[gi];
            end
        end
    endgenerate

    assign arb_found = g_arb[NUM-1].found;
    assign arb_idx   = g_arb[NUM-1].idx;
    assign pass_en   = !rst && (state_q == PASS);

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q      <= RST_HOLD;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= LAST_PORT;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_tdata      = '0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        m_tdest      = '0;
        flush_ack    = 1'b0;
        cache_rst    = 1'b0;
        busy         = 1'b1;

        // While rst is high the outputs already show the reset values.
        if (rst) begin
            cache_rst = 1'b1;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    cache_rst = 1'b1;
                    if (cnt_q == HOLD_END) begin
                        state_d = RST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RST_WAIT: begin
                    if (cnt_q == WAIT_END) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                IDLE: begin
                    busy = 1'b0;
                    if (flush_req) begin
                        flush_ack = 1'b1;
                        state_d   = RST_HOLD;
                        cnt_d     = '0;
                    end else if (arb_found) begin
                        grant_d = arb_idx;
                        state_d = PASS;
                    end
                end
                PASS: begin
                    m_tdata  = port_data[grant_q];
                    m_tvalid = s_tvalid[grant_q];
                    m_tlast  = s_tlast[grant_q];
                    m_tdest  = grant_q;
                    if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = RST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_cache_scheduler.sv
// Directed bench for axi_stream_cache_scheduler: per-cycle comparison against a
// time-budget / owner model, plus literal checks on grant order and timing.
module tb_axi_stream_cache_scheduler;

    localparam int NUM         = 4;
    localparam int DSIZE       = 128;
    localparam int RST_CYCLES  = 8;
    localparam int WAIT_CYCLES = 8;

    logic                 aclk = 1'b0;
    logic                 rst;
    logic [NUM*DSIZE-1:0] s_tdata;
    logic [NUM-1:0]       s_tvalid;
    logic [NUM-1:0]       s_tlast;
    logic [NUM-1:0]       s_tready;
    logic [DSIZE-1:0]     m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic [1:0]           m_tdest;
    logic                 m_tready;
    logic                 flush_req;
    logic                 flush_ack;
    logic                 cache_rst;
    logic                 busy;

    always #5 aclk = ~aclk;

    axi_stream_cache_scheduler #(
        .NUM(NUM), .DSIZE(DSIZE), .RST_CYCLES(RST_CYCLES), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .aclk(aclk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdest(m_tdest),
        .m_tready(m_tready), .flush_req(flush_req), .flush_ack(flush_ack),
        .cache_rst(cache_rst), .busy(busy)
    );

    typedef struct {
        int               cyc;
        int               dest;
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;

    beat_t blog[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Source state: packets still to send, length, current beat, packet id.
    int pk_left [NUM];
    int pk_len  [NUM];
    int bt      [NUM];
    int pk_id   [NUM];

    // Model: remaining hold/settle cycles, owning port (-1 = arbitrating), last completed grant.
    int mo_hold, mo_wait, mo_owner, mo_last;

    int               smp_cyc;
    logic             smp_crst, smp_ack, smp_valid, smp_busy;
    logic [NUM-1:0]   smp_rdy;
    logic [1:0]       smp_dest;
    logic [DSIZE-1:0] smp_data;

    function automatic logic [DSIZE-1:0] pattern(int p, int k, int b);
        logic [31:0] w;
        w = {8'hA5, 8'(p), 8'(k), 8'(b)};
        return {4{w}};
    endfunction

    task automatic chk(string name, logic [DSIZE-1:0] act, logic [DSIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NUM; p++) begin
            s_tvalid[p]                 = (pk_left[p] > 0);
            s_tlast[p]                  = (bt[p] == pk_len[p] - 1);
            s_tdata[p*DSIZE +: DSIZE]   = pattern(p, pk_id[p], bt[p]);
        end
    endtask

    task automatic compare();
        logic             e_crst, e_busy, e_ack, e_valid, e_last;
        logic [1:0]       e_dest;
        logic [DSIZE-1:0] e_data;
        logic [NUM-1:0]   e_rdy;
        e_crst = 1'b0; e_busy = 1'b1; e_ack = 1'b0; e_valid = 1'b0; e_last = 1'b0;
        e_dest = '0; e_data = '0; e_rdy = '0;
        if (rst || mo_hold > 0) begin
            e_crst = 1'b1;
        end else if (mo_wait > 0) begin
            e_crst = 1'b0;
        end else if (mo_owner < 0) begin
            e_busy = 1'b0;
            e_ack  = flush_req;
        end else begin
            e_valid         = s_tvalid[mo_owner];
            e_last          = s_tlast[mo_owner];
            e_data          = s_tdata[mo_owner*DSIZE +: DSIZE];
            e_dest          = 2'(mo_owner);
            e_rdy[mo_owner] = m_tready;
        end
        chk("cache_rst", cache_rst, e_crst);
        chk("busy",      busy,      e_busy);
        chk("flush_ack", flush_ack, e_ack);
        chk("m_tvalid",  m_tvalid,  e_valid);
        chk("m_tlast",   m_tlast,   e_last);
        chk("m_tdest",   m_tdest,   e_dest);
        chk("m_tdata",   m_tdata,   e_data);
        chk("s_tready",  s_tready,  e_rdy);
    endtask

    task automatic model_update();
        if (rst) begin
            mo_hold = RST_CYCLES; mo_wait = WAIT_CYCLES; mo_owner = -1; mo_last = NUM - 1;
        end else if (mo_hold > 0) begin
            mo_hold--;
        end else if (mo_wait > 0) begin
            mo_wait--;
        end else if (mo_owner < 0) begin
            if (flush_req) begin
                mo_hold = RST_CYCLES; mo_wait = WAIT_CYCLES;
            end else begin
                for (int k = 1; k <= NUM; k++) begin
                    if (mo_owner < 0 && s_tvalid[(mo_last + k) % NUM])
                        mo_owner = (mo_last + k) % NUM;
                end
            end
        end else if (s_tvalid[mo_owner] && m_tready && s_tlast[mo_owner]) begin
            mo_last  = mo_owner;
            mo_owner = -1;
        end
    endtask

    task automatic step();
        logic [NUM-1:0] acc;
        @(negedge aclk);
        smp_cyc = cyc;
        compare();
        smp_crst = cache_rst; smp_ack = flush_ack; smp_valid = m_tvalid; smp_busy = busy;
        smp_rdy = s_tready; smp_dest = m_tdest; smp_data = m_tdata;
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            blog.push_back('{cyc, int'(m_tdest), m_tdata, m_tlast});
            $display("cyc %0d beat dest=%0d last=%0b data=%h", cyc, m_tdest, m_tlast, m_tdata);
        end
        @(posedge aclk);
        model_update();
        #1;
        for (int p = 0; p < NUM; p++) begin
            if (acc[p]) begin
                if (s_tlast[p]) begin
                    bt[p] = 0; pk_id[p]++; pk_left[p]--;
                end else begin
                    bt[p]++;
                end
            end
        end
        drive();
        cyc++;
    endtask

    task automatic run_until(int n, int budget, string name);
        int i;
        i = 0;
        while (blog.size() < n && i < budget) begin
            step();
            i++;
        end
        chk(name, blog.size(), n);
    endtask

    initial begin
        int t0, first_rdy, crst_cnt, last_crst, base, sz, lc, ack_cnt, ack_cyc, crst_rise, n;
        int exp_src[5];
        exp_src = '{0, 1, 2, 3, 0};
        mo_hold = RST_CYCLES; mo_wait = WAIT_CYCLES; mo_owner = -1; mo_last = NUM - 1;
        rst = 1'b1; m_tready = 1'b1; flush_req = 1'b0;
        for (int p = 0; p < NUM; p++) begin
            pk_left[p] = 1; pk_len[p] = 3; bt[p] = 0; pk_id[p] = 0;
        end
        pk_left[0] = 2;
        drive();
        repeat (3) step();

        // Reset release, then four ports contending with 3-beat packets.
        rst = 1'b0;
        t0 = cyc; first_rdy = -1; crst_cnt = 0; last_crst = -1;
        while (blog.size() < 15 && cyc < t0 + 120) begin
            step();
            if (first_rdy < 0 && smp_rdy != '0) first_rdy = smp_cyc;
            if (smp_crst) begin crst_cnt++; last_crst = smp_cyc; end
        end
        chk("p2_beats", blog.size(), 15);
        chk("crst_cycles", crst_cnt, 8);
        chk("crst_last", last_crst - t0, 7);
        chk("first_ready", first_rdy - t0, 17);
        chk("first_beat", blog[0].cyc - t0, 17);
        for (int i = 0; i < 5; i++) begin
            chk("grant_order", blog[i*3].dest, exp_src[i]);
            chk("pkt_last", blog[i*3+2].last, 1'b1);
            if (i > 0) chk("pkt_spacing", blog[i*3].cyc - blog[0].cyc, 4 * i);
        end
        chk("mid_not_last", blog[13].last, 1'b0);

        // Port 2 stalled mid-packet while ports 0 and 1 wait.
        base = blog.size();
        pk_left[2] = 1; pk_len[2] = 4; drive();
        run_until(base + 1, 20, "p3_first_beat");
        m_tready = 1'b0;
        pk_left[0] = 1; pk_len[0] = 2; pk_left[1] = 1; pk_len[1] = 2;
        drive();
        repeat (5) begin
            step();
            chk("stall_ready", smp_rdy, '0);
            chk("stall_data", smp_data, pattern(2, 1, 1));
            chk("stall_dest", smp_dest, 2'd2);
        end
        chk("stall_no_accept", blog.size(), base + 1);
        m_tready = 1'b1;
        run_until(base + 4, 20, "p3_finish");
        chk("p3_beat1_data", blog[base+1].data, pattern(2, 1, 1));
        run_until(base + 8, 40, "p3_drain");
        chk("rr_after_2", blog[base+4].dest, 0);
        chk("rr_then_1", blog[base+6].dest, 1);

        // Flush raised on beat 2 of a 4-beat packet from port 1.
        base = blog.size();
        pk_left[1] = 1; pk_len[1] = 4; drive();
        run_until(base + 1, 20, "p4_start");
        flush_req = 1'b1;
        pk_left[3] = 2; pk_len[3] = 1; drive();
        ack_cnt = 0; ack_cyc = -1; crst_rise = -1; n = 0;
        while (blog.size() < base + 5 && n < 60) begin
            step();
            n++;
            if (smp_ack) begin ack_cnt++; ack_cyc = smp_cyc; flush_req = 1'b0; end
            if (smp_crst && crst_rise < 0) crst_rise = smp_cyc;
        end
        chk("p4_beats", blog.size(), base + 5);
        lc = blog[base+3].cyc;
        chk("p4_pkt_dest", blog[base+3].dest, 1);
        chk("p4_pkt_last", blog[base+3].last, 1'b1);
        chk("p4_pkt_contig", lc - blog[base].cyc, 3);
        chk("flush_ack_cyc", ack_cyc - lc, 1);
        chk("flush_ack_count", ack_cnt, 1);
        chk("flush_crst_rise", crst_rise - lc, 2);
        chk("flush_gap", blog[base+4].cyc - lc, 19);
        chk("flush_next_dest", blog[base+4].dest, 3);
        run_until(base + 6, 20, "p4_drain");

        // rst pulsed while port 2 is mid-packet.
        base = blog.size();
        pk_left[1] = 1; pk_len[1] = 2; pk_left[2] = 1; pk_len[2] = 4; drive();
        run_until(base + 4, 30, "p5_pre");
        chk("p5_mid_dest", blog[base+2].dest, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int p = 0; p < NUM; p++) bt[p] = 0;
        pk_left[1] = 1;
        drive();
        step();
        t0 = smp_cyc;
        chk("rst_next_valid", smp_valid, 1'b0);
        chk("rst_next_ready", smp_rdy, '0);
        chk("rst_next_crst", smp_crst, 1'b1);
        chk("rst_next_busy", smp_busy, 1'b1);
        sz = blog.size();
        run_until(sz + 1, 40, "p5_restart");
        chk("rr_restart", blog[sz].dest, 1);
        chk("p5_restart_cyc", blog[sz].cyc - t0, 17);
        run_until(sz + 6, 40, "p5_resend");
        chk("p5_resend_dest", blog[sz+2].dest, 2);
        chk("p5_resend_data", blog[sz+2].data, pattern(2, 2, 0));

        // Port 3 alone with back-to-back single-beat packets.
        base = blog.size();
        pk_left[3] = 5; pk_len[3] = 1; drive();
        run_until(base + 5, 30, "p6_beats");
        for (int i = 0; i < 5; i++) begin
            chk("single_dest", blog[base+i].dest, 3);
            if (i > 0) chk("single_spacing", blog[base+i].cyc - blog[base+i-1].cyc, 2);
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
